// File: rtl/dsp_be_eq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dsp_be_eq_ctrl
// Description : Bring-up / shutdown / reconfiguration sequencer for the
//               backend equalizer pipeline (MLSE ALU -> pattern filter ->
//               MLSE decoder). Releases stage resets and enables in pipeline
//               order, issues a config-apply strobe while quiescent and
//               serialises config-update requests against run/stop.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_be_eq_ctrl #(
    parameter int PRLL_RANK    = 64,
    parameter int RST_HOLD_CYC = 8,
    parameter int ALU_LAT      = 4,
    parameter int FILT_LAT     = 5,
    parameter int DEC_LAT      = 4,
    parameter int CNT_W        = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic [PRLL_RANK-1:0] i_lane_en,
    input  logic                 i_cfg_upd_req,
    output logic                 o_cfg_upd_ack,
    output logic                 o_cfg_apply,
    output logic [PRLL_RANK-1:0] o_rst_alu,
    output logic [PRLL_RANK-1:0] o_rst_filt,
    output logic [PRLL_RANK-1:0] o_rst_dec,
    output logic [PRLL_RANK-1:0] o_en_alu,
    output logic [PRLL_RANK-1:0] o_en_filt,
    output logic [PRLL_RANK-1:0] o_en_dec,
    output logic                 o_running,
    output logic                 o_busy,
    output logic [3:0]           o_state
);

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_HOLD    = 4'd1;
    localparam logic [3:0] ST_APPLY   = 4'd2;
    localparam logic [3:0] ST_UP_ALU  = 4'd3;
    localparam logic [3:0] ST_UP_FILT = 4'd4;
    localparam logic [3:0] ST_UP_DEC  = 4'd5;
    localparam logic [3:0] ST_RUN     = 4'd6;
    localparam logic [3:0] ST_DN_ALU  = 4'd7;
    localparam logic [3:0] ST_DN_FILT = 4'd8;
    localparam logic [3:0] ST_DN_DEC  = 4'd9;

    // Counter load values: a timed state lasting N cycles starts at N-1
    // and exits when the counter reaches zero.
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] ALU_LD  = CNT_W'(ALU_LAT - 1);
    localparam logic [CNT_W-1:0] FILT_LD = CNT_W'(FILT_LAT - 1);
    localparam logic [CNT_W-1:0] DEC_LD  = CNT_W'(DEC_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [3:0]           state;
    logic [3:0]           state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 cnt_done;
    logic [PRLL_RANK-1:0] lane_q;
    logic [PRLL_RANK-1:0] lane_nxt;
    logic                 upd_pend;
    logic                 upd_pend_nxt;
    logic                 auto_go;
    logic                 auto_go_nxt;
    logic                 ack_nxt;
    logic                 rel_alu;
    logic                 rel_filt;
    logic                 rel_dec;
    logic                 rel_alu_nxt;
    logic                 rel_filt_nxt;
    logic                 rel_dec_nxt;
    logic                 alu_win;
    logic                 filt_win;
    logic                 dec_win;
    logic [PRLL_RANK-1:0] en_alu_nxt;
    logic [PRLL_RANK-1:0] en_filt_nxt;
    logic [PRLL_RANK-1:0] en_dec_nxt;

    assign cnt_done = (cnt == '0);
    assign o_state  = state;

    // Sequencer next-state: stop has priority over update, update-driven
    // drains re-enter bring-up through IDLE via the auto-start flag.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt_done ? cnt : (cnt - CNT_ONE);
        lane_nxt    = lane_q;
        auto_go_nxt = auto_go;
        ack_nxt     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start || auto_go) begin
                    state_nxt   = ST_HOLD;
                    cnt_nxt     = HOLD_LD;
                    lane_nxt    = i_lane_en;
                    auto_go_nxt = 1'b0;
                end
            end
            ST_HOLD: begin
                if (i_stop) begin
                    state_nxt = ST_IDLE;
                end else if (cnt_done) begin
                    state_nxt = ST_APPLY;
                end
            end
            ST_APPLY: begin
                if (i_stop) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_UP_ALU;
                    cnt_nxt   = ALU_LD;
                end
            end
            ST_UP_ALU: begin
                if (i_stop) begin
                    state_nxt = ST_DN_ALU;
                    cnt_nxt   = ALU_LD;
                end else if (cnt_done) begin
                    state_nxt = ST_UP_FILT;
                    cnt_nxt   = FILT_LD;
                end
            end
            ST_UP_FILT: begin
                if (i_stop) begin
                    state_nxt = ST_DN_ALU;
                    cnt_nxt   = ALU_LD;
                end else if (cnt_done) begin
                    state_nxt = ST_UP_DEC;
                    cnt_nxt   = DEC_LD;
                end
            end
            ST_UP_DEC: begin
                if (i_stop) begin
                    state_nxt = ST_DN_ALU;
                    cnt_nxt   = ALU_LD;
                end else if (cnt_done) begin
                    state_nxt = ST_RUN;
                    ack_nxt   = upd_pend;
                end
            end
            ST_RUN: begin
                if (i_stop) begin
                    state_nxt = ST_DN_ALU;
                    cnt_nxt   = ALU_LD;
                end else if (upd_pend) begin
                    state_nxt   = ST_DN_ALU;
                    cnt_nxt     = ALU_LD;
                    auto_go_nxt = 1'b1;
                end
            end
            ST_DN_ALU: begin
                if (cnt_done) begin
                    state_nxt = ST_DN_FILT;
                    cnt_nxt   = FILT_LD;
                end
            end
            ST_DN_FILT: begin
                if (cnt_done) begin
                    state_nxt = ST_DN_DEC;
                    cnt_nxt   = DEC_LD;
                end
            end
            ST_DN_DEC: begin
                if (cnt_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Release flags, enable windows and update-pending bookkeeping derived
    // from the upcoming state so every output can be registered.
    always_comb begin
        rel_alu_nxt  = rel_alu;
        rel_filt_nxt = rel_filt;
        rel_dec_nxt  = rel_dec;
        if (state_nxt == ST_IDLE) begin
            rel_alu_nxt  = 1'b0;
            rel_filt_nxt = 1'b0;
            rel_dec_nxt  = 1'b0;
        end else begin
            if (state_nxt == ST_UP_ALU)  rel_alu_nxt  = 1'b1;
            if (state_nxt == ST_UP_FILT) rel_filt_nxt = 1'b1;
            if (state_nxt == ST_UP_DEC)  rel_dec_nxt  = 1'b1;
        end
        // Downstream windows extend into the drain so each stage keeps
        // running until its upstream neighbour has flushed.
        alu_win  = state_nxt inside {ST_UP_ALU, ST_UP_FILT, ST_UP_DEC, ST_RUN};
        filt_win = rel_filt_nxt &&
                   (state_nxt inside {ST_UP_FILT, ST_UP_DEC, ST_RUN, ST_DN_ALU});
        dec_win  = rel_dec_nxt &&
                   (state_nxt inside {ST_UP_DEC, ST_RUN, ST_DN_ALU, ST_DN_FILT});
        en_alu_nxt  = alu_win  ? lane_nxt : '0;
        en_filt_nxt = filt_win ? lane_nxt : '0;
        en_dec_nxt  = dec_win  ? lane_nxt : '0;
        // The cycle showing ack still carries the held request; it is not
        // counted as a new one.
        upd_pend_nxt = ack_nxt ? 1'b0 : (upd_pend | (i_cfg_upd_req & ~o_cfg_upd_ack));
    end

    // Sequencer state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            lane_q   <= '0;
            upd_pend <= 1'b0;
            auto_go  <= 1'b0;
            rel_alu  <= 1'b0;
            rel_filt <= 1'b0;
            rel_dec  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            lane_q   <= lane_nxt;
            upd_pend <= upd_pend_nxt;
            auto_go  <= auto_go_nxt;
            rel_alu  <= rel_alu_nxt;
            rel_filt <= rel_filt_nxt;
            rel_dec  <= rel_dec_nxt;
        end
    end

    // Registered (Moore) outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rst_alu     <= '1;
            o_rst_filt    <= '1;
            o_rst_dec     <= '1;
            o_en_alu      <= '0;
            o_en_filt     <= '0;
            o_en_dec      <= '0;
            o_cfg_upd_ack <= 1'b0;
            o_cfg_apply   <= 1'b0;
            o_running     <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            o_rst_alu     <= ~({PRLL_RANK{rel_alu_nxt}}  & lane_nxt);
            o_rst_filt    <= ~({PRLL_RANK{rel_filt_nxt}} & lane_nxt);
            o_rst_dec     <= ~({PRLL_RANK{rel_dec_nxt}}  & lane_nxt);
            o_en_alu      <= en_alu_nxt;
            o_en_filt     <= en_filt_nxt;
            o_en_dec      <= en_dec_nxt;
            o_cfg_upd_ack <= ack_nxt;
            o_cfg_apply   <= (state_nxt == ST_APPLY);
            o_running     <= (state_nxt == ST_RUN);
            o_busy        <= (state_nxt != ST_IDLE) && (state_nxt != ST_RUN);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dsp_be_eq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsp_be_eq_ctrl
// Description : Self-checking bench for dsp_be_eq_ctrl. A timeline model
//               (absolute cycle of bring-up start / drain start) predicts
//               every output each cycle; directed latency checks use the
//               fixed cycle numbers of the default configuration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_be_eq_ctrl;

    localparam int P = 64;
    localparam int H = 8;
    localparam int A = 4;
    localparam int F = 5;
    localparam int D = 4;
    // Offsets (from first HOLD cycle) at which each stage is released / RUN starts
    localparam int OA   = H + 1;
    localparam int OF   = H + 1 + A;
    localparam int OD   = H + 1 + A + F;
    localparam int ORUN = H + 1 + A + F + D;
    localparam int DTOT = A + F + D;

    localparam int P_IDLE = 0, P_HOLD = 1, P_APPLY = 2, P_UPA = 3, P_UPF = 4,
                   P_UPD = 5, P_RUN = 6, P_DNA = 7, P_DNF = 8, P_DND = 9;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         cfg_req = 1'b0;
    logic [P-1:0] lane_en = '1;
    logic         cfg_ack, cfg_apply, running, busy;
    logic [P-1:0] rst_alu, rst_filt, rst_dec, en_alu, en_filt, en_dec;
    logic [3:0]   state_dbg;

    dsp_be_eq_ctrl #(
        .PRLL_RANK(P), .RST_HOLD_CYC(H), .ALU_LAT(A), .FILT_LAT(F),
        .DEC_LAT(D), .CNT_W(8)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
        .i_lane_en(lane_en), .i_cfg_upd_req(cfg_req),
        .o_cfg_upd_ack(cfg_ack), .o_cfg_apply(cfg_apply),
        .o_rst_alu(rst_alu), .o_rst_filt(rst_filt), .o_rst_dec(rst_dec),
        .o_en_alu(en_alu), .o_en_filt(en_filt), .o_en_dec(en_dec),
        .o_running(running), .o_busy(busy), .o_state(state_dbg)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int           c = 0;        // current cycle index
    int           mode = 0;     // 0 idle, 1 bring-up/run from t0, 2 drain from tdn
    int           t0 = 0;
    int           tdn = 0;
    logic [P-1:0] m_lane = '0;
    bit           m_upd = 1'b0;
    bit           m_auto = 1'b0;
    bit           m_ack = 1'b0;
    bit           ack_prev = 1'b0;

    int ncmp = 0;
    int nfail = 0;

    function automatic int phase_of(input int m, input int cc);
        int k;
        if (m == 0) return P_IDLE;
        if (m == 1) begin
            k = cc - t0;
            if (k < H)    return P_HOLD;
            if (k == H)   return P_APPLY;
            if (k < OF)   return P_UPA;
            if (k < OD)   return P_UPF;
            if (k < ORUN) return P_UPD;
            return P_RUN;
        end
        k = cc - tdn;
        if (k < A)     return P_DNA;
        if (k < A + F) return P_DNF;
        if (k < DTOT)  return P_DND;
        return P_IDLE;
    endfunction

    function automatic bit rel_of(input int off);
        if (mode == 1) return (c - t0) >= off;
        if (mode == 2) return (tdn - 1 - t0) >= off;
        return 1'b0;
    endfunction

    task automatic model_reset();
        mode = 0; m_upd = 0; m_auto = 0; m_ack = 0; m_lane = '0;
        t0 = 0; tdn = 0;
    endtask

    // Advance the model across the clock edge that ends cycle c.
    task automatic model_step();
        int p;
        bit ack_n;
        p = phase_of(mode, c);
        ack_n = 1'b0;
        case (p)
            P_IDLE: if (start || m_auto) begin
                mode = 1; t0 = c + 1; m_lane = lane_en; m_auto = 0;
            end
            P_HOLD, P_APPLY: if (stop) mode = 0;
            P_UPA, P_UPF, P_UPD: begin
                if (stop) begin
                    mode = 2; tdn = c + 1;
                end else if (phase_of(1, c + 1) == P_RUN && m_upd) begin
                    ack_n = 1'b1;
                end
            end
            P_RUN: begin
                if (stop) begin
                    mode = 2; tdn = c + 1;
                end else if (m_upd) begin
                    mode = 2; tdn = c + 1; m_auto = 1;
                end
            end
            default: if (c + 1 - tdn == DTOT) mode = 0;
        endcase
        m_upd = ack_n ? 1'b0 : (m_upd | (cfg_req & ~m_ack));
        m_ack = ack_n;
        c++;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [P-1:0] obs, input logic [P-1:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, c, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, c, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int p;
        bit ra, rf, rd;
        p  = phase_of(mode, c);
        ra = rel_of(OA);
        rf = rel_of(OF);
        rd = rel_of(OD);
        chk("rst_alu",  rst_alu,  ra ? ~m_lane : '1);
        chk("rst_filt", rst_filt, rf ? ~m_lane : '1);
        chk("rst_dec",  rst_dec,  rd ? ~m_lane : '1);
        chk("en_alu",   en_alu,   (p >= P_UPA && p <= P_RUN) ? m_lane : '0);
        chk("en_filt",  en_filt,
            (rf && (p == P_UPF || p == P_UPD || p == P_RUN || p == P_DNA)) ? m_lane : '0);
        chk("en_dec",   en_dec,
            (rd && (p == P_UPD || p == P_RUN || p == P_DNA || p == P_DNF)) ? m_lane : '0);
        chk1("apply",   cfg_apply, p == P_APPLY);
        chk1("ack",     cfg_ack,   m_ack);
        chk1("running", running,   p == P_RUN);
        chk1("busy",    busy,      p != P_IDLE && p != P_RUN);
    endtask

    // One clock: model follows the edge, outputs checked 1 time unit later,
    // requester drops its request the cycle after it sees the ack.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        else c++;
        #1;
        check_all();
        if (ack_prev) cfg_req = 1'b0;
        ack_prev = m_ack;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Start with all lanes and verify the absolute bring-up timestamps.
    task automatic bringup_timing(input string tag);
        int ts, fa, fra, frf, frd, fr;
        fa = -1; fra = -1; frf = -1; frd = -1; fr = -1;
        lane_en = '1;
        start = 1'b1;
        ts = c;
        tick();
        start = 1'b0;
        for (int i = 0; i < 26; i++) begin
            if (fa  < 0 && cfg_apply)     fa  = c;
            if (fra < 0 && rst_alu  == '0) fra = c;
            if (frf < 0 && rst_filt == '0) frf = c;
            if (frd < 0 && rst_dec  == '0) frd = c;
            if (fr  < 0 && running)       fr  = c;
            tick();
        end
        chki({tag, "_apply_cyc"},   fa  - ts, 9);
        chki({tag, "_rstalu_cyc"},  fra - ts, 10);
        chki({tag, "_rstfilt_cyc"}, frf - ts, 14);
        chki({tag, "_rstdec_cyc"},  frd - ts, 19);
        chki({tag, "_run_cyc"},     fr  - ts, 23);
    endtask

    initial begin
        int ts, n_apply, n_ack, idle_at;
        model_reset();

        // Reset state
        ticks(3);
        rst_n = 1'b1;
        ticks(2);

        // Nominal bring-up with all lanes
        bringup_timing("boot");

        // Mask change in RUN has no effect; then stop and full drain
        lane_en = {$urandom, $urandom};
        ticks(3);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        ticks(16);

        // Partial lane mask with a held config-update request in RUN
        lane_en = 64'h0000_0000_0000_00FF;
        start = 1'b1;
        tick();
        start = 1'b0;
        ticks(24);
        lane_en = {$urandom, $urandom};
        cfg_req = 1'b1;
        n_apply = 0;
        n_ack = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (cfg_apply) n_apply++;
            if (cfg_ack)   n_ack++;
        end
        chki("upd_apply_pulses", n_apply, 1);
        chki("upd_ack_pulses",   n_ack,   1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        ticks(16);

        // Stop during UP_ALU (cycle 11 after start)
        lane_en = '1;
        start = 1'b1;
        ts = c;
        tick();
        start = 1'b0;
        ticks(10);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        idle_at = -1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (idle_at < 0 && !busy && !running) idle_at = c;
        end
        chki("upalu_stop_idle_cyc", idle_at - ts, 25);

        // Stop and update together in RUN: stop wins, ack on next RUN entry
        lane_en = {$urandom, $urandom};
        start = 1'b1;
        tick();
        start = 1'b0;
        ticks(24);
        stop = 1'b1;
        cfg_req = 1'b1;
        tick();
        stop = 1'b0;
        ticks(20);
        start = 1'b1;
        tick();
        start = 1'b0;
        ticks(28);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        ticks(16);

        // Asynchronous reset in UP_FILT, then a full bring-up again
        lane_en = '1;
        start = 1'b1;
        tick();
        start = 1'b0;
        ticks(15);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        ticks(2);
        rst_n = 1'b1;
        tick();
        bringup_timing("rearm");
        stop = 1'b1;
        tick();
        stop = 1'b0;
        ticks(16);

        // Randomised start/stop/update/mask traffic
        for (int i = 0; i < 2000; i++) begin
            start = ($urandom_range(0, 11) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       lane_en = '0;
                    1:       lane_en = '1;
                    default: lane_en = {$urandom, $urandom};
                endcase
            end
            if (!cfg_req && $urandom_range(0, 49) == 0) cfg_req = 1'b1;
            tick();
        end
        start = 1'b0;
        stop = 1'b0;
        ticks(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dsp_be_eq_ctrl.md
Name: dsp_be_eq_ctrl

Overview:
- Bring-up, shutdown and reconfiguration sequencer for the backend equalizer pipeline (MLSE ALU -> pattern filter -> MLSE decoder).
- Drives per-lane stage reset and enable vectors in pipeline order, honouring each stage's latency so no stage consumes data from an un-flushed upstream stage.
- Issues a single-cycle config-apply strobe while the datapath is quiescent; equalizer config registers latch on this strobe.
- Serialises config-update requests against run/stop commands.

Parameters:
- PRLL_RANK, 64, lanes per stage (width of every rst/en vector).
- RST_HOLD_CYC, 8, cycles all stage resets are held after start (>=1).
- ALU_LAT, 4, ALU pipeline latency in cycles (PRE+PST depth, >=1).
- FILT_LAT, 5, pattern-filter latency in cycles (>=1).
- DEC_LAT, 4, decoder latency in cycles (>=1).
- CNT_W, 8, width of the wait counter; must hold max(RST_HOLD_CYC, *_LAT).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  level/pulse; sampled only in IDLE
- i_stop  in  1  level/pulse; request shutdown
- i_lane_en  in  PRLL_RANK  lane mask; sampled on IDLE->HOLD only
- i_cfg_upd_req  in  1  level; held by requester until ack
- o_cfg_upd_ack  out  1  one-cycle pulse
- o_cfg_apply  out  1  one-cycle strobe; config registers latch on it
- o_rst_alu / o_rst_filt / o_rst_dec  out  PRLL_RANK each  active-high stage resets
- o_en_alu / o_en_filt / o_en_dec  out  PRLL_RANK each  stage enables
- o_running  out  1  high in RUN
- o_busy  out  1  high in any state except IDLE and RUN
- o_state  out  4  state encoding, debug only

Behaviour:
- All outputs are registered (Moore). Reset values:
  - rst vectors all ones.
  - en vectors all zeros.
  - ack, apply, running and busy = 0.
  - state = IDLE.
  - lane_q = 0; upd_pend = 0; rel_alu, rel_filt and rel_dec = 0.
- States and transitions:
  - IDLE: on start go to HOLD and latch lane_q = i_lane_en.
  - HOLD: lasts RST_HOLD_CYC cycles, then APPLY.
  - APPLY: 1 cycle with o_cfg_apply = 1, then UP_ALU.
  - UP_ALU, UP_FILT, UP_DEC: each lasts its *_LAT cycles. After UP_DEC, go to RUN.
  - RUN: remains until stop or upd_pend.
  - DN_ALU, DN_FILT, DN_DEC: each lasts its *_LAT cycles, then IDLE.
- Stage release flags:
  - rel_x is set on entry to UP_x and cleared on entry to IDLE.
  - o_rst_x[k] = ~(rel_x & lane_q[k]).
- Enables (registered) are gated by lane_q[k]:
  - en_alu: UP_*, RUN.
  - en_filt: rel_filt & (UP_FILT, UP_DEC, RUN, DN_ALU).
  - en_dec: rel_dec & (UP_DEC, RUN, DN_ALU, DN_FILT).
  - Downstream stages therefore stay enabled while upstream drains.
- Latency: start sampled in cycle t gives o_cfg_apply at t+H+1 and o_running at t+H+2+A+F+D (defaults: t+9, t+23).
- Config update:
  - upd_pend is set whenever i_cfg_upd_req = 1 and no ack is issued that cycle.
  - In RUN with upd_pend and no stop: full drain (DN_*), then IDLE with an internal auto-start. lane_q is re-latched on that auto-start.
  - o_cfg_upd_ack pulses on the first RUN cycle after any bring-up with upd_pend = 1; upd_pend clears in the same cycle.
  - Requester must drop req the cycle after ack. A req still high then is treated as a new request.
- Boundary conditions:
  - Stop and upd in RUN in the same cycle: stop wins, upd_pend is kept, IDLE is held (no auto-start), and ack comes on the next RUN entry.
  - Stop in HOLD or APPLY: go to IDLE next cycle; apply is not issued if not yet reached.
  - Stop in UP_*: go to DN_ALU. Stages not yet released stay in reset (rel flags).
  - i_start outside IDLE: ignored. i_stop in DN_*, IDLE: ignored.
  - Lane mask all zero: the sequence runs normally with all rst=1 and all en=0.
  - i_rst_n low mid-operation: all outputs return to reset values asynchronously; a pending update is lost.

Test Plan:
- Defaults, i_lane_en = all ones, start at cycle 0 -> apply at cycle 9; o_rst_alu = 0 from cycle 10; o_rst_filt = 0 from 14; o_rst_dec = 0 from 19; o_running = 1 at 23.
- Stop in RUN -> en_alu = 0 at the next cycle; en_filt = 0 after 4 cycles; en_dec = 0 after 9; all rst = 1 and IDLE after 13.
- cfg_upd_req held in RUN -> drain, re-hold, exactly one apply pulse, one ack pulse on the first RUN cycle; req dropped -> no second cycle.
- i_lane_en = 0x...00FF -> only lanes 0-7 see rst = 0 and en = 1; mask change during RUN has no effect until the next start.
- Stop during UP_ALU, cycle 11 -> DN_ALU; o_rst_filt and o_rst_dec stay all ones throughout; IDLE after 13 cycles.
- i_rst_n asserted in UP_FILT -> same-cycle return to rst = all ones and en = 0; a following start repeats the full 23-cycle bring-up.
